walk_ctrl: RTL and testbench
============================

Name: walk_ctrl

Overview:
Sequences protagonist movement on the 8x8-tile overworld (CEL scene). Decodes keyboard arrow codes, checks the fixed 10x10 collision map, and steps the protagonist tile position with frame-paced pixel animation. Drives the Graphics sprite position and facing, and the at_prof / at_comp flags. Sits between the keyboard decoder, the top-level game FSM and Graphics.

Parameters:
STEP_FRAMES, 8, frames per tile step; power of two, 1..32
HOME_X, 3, tile x loaded on reset and force_home
HOME_Y, 7, tile y loaded on reset and force_home

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  high while game state is CEL
force_home  in  1  reload home tile (ATTACK entry)
kb_data_avail  in  1  one-cycle strobe, kb_data valid
kb_data  in  8  scan code; only UP/DOWN/LEFT/RIGHT_ARROW are used
screen_tick  in  1  one-cycle pulse per frame (pix 0,0)
prof_tx, prof_ty  in  3 each  professor tile position
protag_x, protag_y  out  3 each  committed tile position
facing  out  2  FORWARD=00, BACKWARD=01, LEFT=10, RIGHT=11
walk_off  out  5  pixel offset toward the target tile, 0..31
moving  out  1  high in WALK
at_prof  out  1  protag tile == prof tile
at_comp  out  1  (0,2), facing BACKWARD, not moving

Behaviour:
- Reset (async, low): protag = (HOME_X, HOME_Y); facing FORWARD; walk_off 0; moving 0; pending empty; state IDLE.
- Collision map: row r (0..9) is a 10-bit vector with bit index 0 as the leftmost column. Rows: 1111111111, 1111111111, 1100000001, 1000110001 (x4), 1000000001 (x2), 1111111111. Tile (x,y) is blocked when map[y+1][x+1] = 1. All arithmetic uses 4-bit indices, so x-1 at x=0 reads the border column (blocked). Position never wraps.
- IDLE: on an arrow strobe with enable=1, facing is registered to the arrow's direction (UP gives BACKWARD, DOWN gives FORWARD), visible the next cycle. If the target tile is free, go to WALK and latch the direction. If blocked, stay in IDLE; facing still updates (bump).
- Non-arrow codes are ignored. A strobe with enable=0 is ignored.
- WALK: moving=1. Each screen_tick adds 32/STEP_FRAMES to walk_off. On the tick where the sum would reach 32: commit protag_x/y to the target, set walk_off to 0, set moving to 0, return to IDLE.
- Pending buffer: one entry. An arrow strobe during WALK is stored, and a later strobe overwrites it. On the cycle after commit, the pending entry is processed exactly as an IDLE strobe, then cleared.
- A strobe coincident with the commit cycle goes into pending.
- enable falling mid-WALK: abort. walk_off=0, moving=0, position unchanged, pending cleared, IDLE.
- force_home: loads the home tile, sets facing BACKWARD, and aborts as above. It has priority over any strobe in the same cycle.
- at_prof and at_comp are combinational from the registered state.

Optional Feature:
WALK_ANIM_EN. When defined, movement is animated as described above. When undefined, WALK is removed: a free-target strobe commits the position on the next clock edge, walk_off is tied to 0, moving is tied to 0, and the pending buffer is absent. Facing and collision behaviour are identical in both builds.

Decomposition:
- Shared package / header (ecemon.vh): arrow scan codes, facing encodings, map row constants, tile-size constant (32).
- One sub-module, collision_map: combinational lookup from (x, y, dir) to blocked.

Test Plan:
1. Reset then UP strobe at (3,7) with STEP_FRAMES=8 → facing 01; walk_off goes 4, 8 … 28 over 7 ticks; on the 8th tick protag_y=6, walk_off=0, moving=0.
2. At (3,6) press UP → target (3,5) blocked; position stays (3,6); facing=01; moving stays 0.
3. At (0,3) press LEFT → blocked by border; then UP twice → reaches (0,2), then bumps at (0,1); at_comp=1.
4. During a walk, press RIGHT then DOWN → after commit exactly one DOWN step follows; RIGHT is discarded.
5. Drop enable mid-walk (walk_off=12) → next cycle walk_off=0, moving=0, position unchanged; a later UP starts a fresh step.
6. force_home pulse together with an arrow strobe at (5,2) → protag=(3,7), facing=01, no step; prof at (3,7) gives at_prof=1.

Source files
------------

// File: rtl/walk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : walk_ctrl_pkg
// Description : Shared definitions for the overworld walk controller:
//               arrow scan codes, facing encodings, FSM state type, tile
//               struct, collision map rows, and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package walk_ctrl_pkg;

  // Pixels per tile edge; walk_off counts up toward this value.
  localparam int TILE_PX = 32;

  // Extended-set keyboard scan codes for the arrow keys.
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    FACE_FORWARD  = 2'b00,
    FACE_BACKWARD = 2'b01,
    FACE_LEFT     = 2'b10,
    FACE_RIGHT    = 2'b11
  } facing_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_t;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } tile_t;

  // Map rows, bit 0 = leftmost column. The map is framed by a border so the
  // 8x8 playfield lives at rows/cols 1..8.
  localparam logic [9:0] MAP_ROW_BORDER = 10'b11_1111_1111;
  localparam logic [9:0] MAP_ROW_TOP    = 10'b10_0000_0011;
  localparam logic [9:0] MAP_ROW_PILLAR = 10'b10_0011_0001;
  localparam logic [9:0] MAP_ROW_OPEN   = 10'b10_0000_0001;

  function automatic logic [9:0] map_row(input logic [3:0] r);
    logic [9:0] bits;
    case (r)
      4'd2:                   bits = MAP_ROW_TOP;
      4'd3, 4'd4, 4'd5, 4'd6: bits = MAP_ROW_PILLAR;
      4'd7, 4'd8:             bits = MAP_ROW_OPEN;
      default:                bits = MAP_ROW_BORDER;
    endcase
    return bits;
  endfunction

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == KEY_UP) || (code == KEY_DOWN) ||
           (code == KEY_LEFT) || (code == KEY_RIGHT);
  endfunction

  // UP walks away from the viewer, hence BACKWARD.
  function automatic facing_t arrow_dir(input logic [7:0] code);
    facing_t d;
    case (code)
      KEY_UP:    d = FACE_BACKWARD;
      KEY_LEFT:  d = FACE_LEFT;
      KEY_RIGHT: d = FACE_RIGHT;
      default:   d = FACE_FORWARD;
    endcase
    return d;
  endfunction

  // Neighbour tile in direction d. Only used when the neighbour is free, so
  // the 3-bit wrap at the edges never reaches a register.
  function automatic tile_t step_tile(input tile_t t, input facing_t d);
    tile_t n;
    n = t;
    case (d)
      FACE_FORWARD:  n.y = t.y + 3'd1;
      FACE_BACKWARD: n.y = t.y - 3'd1;
      FACE_LEFT:     n.x = t.x - 3'd1;
      FACE_RIGHT:    n.x = t.x + 3'd1;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/walk_ctrl_collision_map.sv
`default_nettype none
// ============================================================================
// Module      : walk_ctrl_collision_map
// Description : Combinational lookup: is the tile next to (x,y) in direction
//               dir blocked on the fixed 10x10 collision map?
// Ports       : x, y    in  3  current tile
//               dir     in  2  direction of the intended step
//               blocked out 1  target tile is a wall or border
// Revision    : 1.0 - initial release
// ============================================================================
module walk_ctrl_collision_map
  import walk_ctrl_pkg::*;
(
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  facing_t    dir,
  output logic       blocked
);

  logic [3:0] col;
  logic [3:0] row;
  logic [9:0] row_bits;

  // Map indices are tile+1 (border offset); a step left from x=0 lands on
  // column 0, which is border and therefore blocked.
  always_comb begin
    col = {1'b0, x} + 4'd1;
    row = {1'b0, y} + 4'd1;
    case (dir)
      FACE_LEFT:     col = {1'b0, x};
      FACE_RIGHT:    col = {1'b0, x} + 4'd2;
      FACE_BACKWARD: row = {1'b0, y};
      FACE_FORWARD:  row = {1'b0, y} + 4'd2;
    endcase
    row_bits = map_row(row);
    blocked  = (col > 4'd9) ? 1'b1 : row_bits[col];
  end

endmodule
`default_nettype wire

// File: rtl/walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : walk_ctrl
// Description : Protagonist movement sequencer for the CEL overworld. Decodes
//               arrow keys, checks collision, and steps the tile position
//               with frame-paced pixel animation.
// Config      : WALK_ANIM_EN - when defined, steps are animated over
//               STEP_FRAMES frames with a one-entry pending key buffer. When
//               undefined, a free step commits on the next clock edge.
// Ports       : clock, reset (async, active-low)
//               enable, force_home, kb_data_avail, kb_data[7:0], screen_tick
//               prof_tx[2:0], prof_ty[2:0]  professor tile
//               protag_x/y[2:0], facing[1:0], walk_off[4:0], moving,
//               at_prof, at_comp
// Revision    : 1.0 - initial release
// ============================================================================
module walk_ctrl
  import walk_ctrl_pkg::*;
#(
  parameter int STEP_FRAMES = 8,
  parameter int HOME_X      = 3,
  parameter int HOME_Y      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       force_home,
  input  logic       kb_data_avail,
  input  logic [7:0] kb_data,
  input  logic       screen_tick,
  input  logic [2:0] prof_tx,
  input  logic [2:0] prof_ty,
  output logic [2:0] protag_x,
  output logic [2:0] protag_y,
  output logic [1:0] facing,
  output logic [4:0] walk_off,
  output logic       moving,
  output logic       at_prof,
  output logic       at_comp
);

  localparam logic [5:0] STEP_INC  = 6'(TILE_PX / STEP_FRAMES);
  localparam tile_t      HOME_TILE = '{x: 3'(HOME_X), y: 3'(HOME_Y)};

  tile_t   r_pos;
  facing_t r_facing;

  logic    w_key_valid;
  facing_t w_key_dir;
  logic    w_req_valid;
  facing_t w_req_dir;
  logic    w_req_blocked;
  tile_t   w_req_target;

  assign w_key_valid  = kb_data_avail & enable & is_arrow(kb_data);
  assign w_key_dir    = arrow_dir(kb_data);
  assign w_req_target = step_tile(r_pos, w_req_dir);

  walk_ctrl_collision_map u_collision_map (
    .x       (r_pos.x),
    .y       (r_pos.y),
    .dir     (w_req_dir),
    .blocked (w_req_blocked)
  );

`ifdef WALK_ANIM_EN

  walk_state_t r_state;
  logic        r_pend_valid;
  facing_t     r_pend_dir;
  tile_t       r_target;
  logic [4:0]  r_walk_off;
  logic        r_moving;
  logic [5:0]  w_off_sum;

  // In IDLE a live key wins over the buffered one (newest input, same as the
  // overwrite rule while walking); the buffer is dropped either way.
  assign w_req_valid = (r_state == ST_IDLE) & (w_key_valid | (r_pend_valid & enable));
  assign w_req_dir   = w_key_valid ? w_key_dir : r_pend_dir;
  assign w_off_sum   = {1'b0, r_walk_off} + STEP_INC;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pos        <= HOME_TILE;
      r_facing     <= FACE_FORWARD;
      r_target     <= HOME_TILE;
      r_walk_off   <= 5'd0;
      r_moving     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_dir   <= FACE_FORWARD;
    end else if (force_home) begin
      r_state      <= ST_IDLE;
      r_pos        <= HOME_TILE;
      r_facing     <= FACE_BACKWARD;
      r_walk_off   <= 5'd0;
      r_moving     <= 1'b0;
      r_pend_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pend_valid <= 1'b0;
          if (w_req_valid) begin
            r_facing <= w_req_dir;
            if (!w_req_blocked) begin
              r_target <= w_req_target;
              r_state  <= ST_WALK;
              r_moving <= 1'b1;
            end
          end
        end
        ST_WALK: begin
          if (!enable) begin
            r_state      <= ST_IDLE;
            r_walk_off   <= 5'd0;
            r_moving     <= 1'b0;
            r_pend_valid <= 1'b0;
          end else begin
            if (w_key_valid) begin
              r_pend_valid <= 1'b1;
              r_pend_dir   <= w_key_dir;
            end
            if (screen_tick) begin
              if (w_off_sum[5]) begin
                r_pos      <= r_target;
                r_walk_off <= 5'd0;
                r_moving   <= 1'b0;
                r_state    <= ST_IDLE;
              end else begin
                r_walk_off <= w_off_sum[4:0];
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign walk_off = r_walk_off;
  assign moving   = r_moving;

`else

  assign w_req_valid = w_key_valid;
  assign w_req_dir   = w_key_dir;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pos    <= HOME_TILE;
      r_facing <= FACE_FORWARD;
    end else if (force_home) begin
      r_pos    <= HOME_TILE;
      r_facing <= FACE_BACKWARD;
    end else if (w_req_valid) begin
      r_facing <= w_req_dir;
      if (!w_req_blocked) begin
        r_pos <= w_req_target;
      end
    end
  end

  assign walk_off = 5'd0;
  assign moving   = 1'b0;

  // Frame pacing has no role without animation.
  logic unused_sink;
  assign unused_sink = ^{screen_tick, STEP_INC};

`endif

  assign protag_x = r_pos.x;
  assign protag_y = r_pos.y;
  assign facing   = r_facing;
  assign at_prof  = (r_pos.x == prof_tx) && (r_pos.y == prof_ty);
  assign at_comp  = (r_pos.x == 3'd0) && (r_pos.y == 3'd2) &&
                    (r_facing == FACE_BACKWARD) && !moving;

endmodule
`default_nettype wire

// File: tb/tb_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_walk_ctrl
// Description : Self-checking bench for walk_ctrl. A behavioural model built
//               from the map as text rows and integer tile arithmetic
//               predicts every output; directed scenarios plus a random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_walk_ctrl;

  localparam int SF = 8;
  localparam int HX = 3;
  localparam int HY = 7;
`ifdef WALK_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       force_home;
  logic       kb_data_avail;
  logic [7:0] kb_data;
  logic       screen_tick;
  logic [2:0] prof_tx;
  logic [2:0] prof_ty;
  logic [2:0] protag_x;
  logic [2:0] protag_y;
  logic [1:0] facing;
  logic [4:0] walk_off;
  logic       moving;
  logic       at_prof;
  logic       at_comp;

  int checks = 0;
  int errors = 0;

  walk_ctrl #(.STEP_FRAMES(SF), .HOME_X(HX), .HOME_Y(HY)) dut (
    .clock(clock), .reset(reset), .enable(enable), .force_home(force_home),
    .kb_data_avail(kb_data_avail), .kb_data(kb_data), .screen_tick(screen_tick),
    .prof_tx(prof_tx), .prof_ty(prof_ty), .protag_x(protag_x), .protag_y(protag_y),
    .facing(facing), .walk_off(walk_off), .moving(moving), .at_prof(at_prof),
    .at_comp(at_comp)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  string rows [10] = '{"1111111111", "1111111111", "1100000001", "1000110001",
                       "1000110001", "1000110001", "1000110001", "1000000001",
                       "1000000001", "1111111111"};

  int mx, my, mface, moff, mpend, mtx, mty;
  bit mwalk;

  function automatic bit mblocked(int x, int y);
    string r;
    if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b1;
    r = rows[y + 1];
    return r[x + 1] == 8'h31;
  endfunction

  function automatic int code_dir(logic [7:0] c);
    if (c == K_UP)    return 1;
    if (c == K_DOWN)  return 0;
    if (c == K_LEFT)  return 2;
    if (c == K_RIGHT) return 3;
    return -1;
  endfunction

  function automatic bit m_at_comp();
    return (mx == 0) && (my == 2) && (mface == 1) && !mwalk;
  endfunction

  task automatic model_reset();
    mx = HX; my = HY; mface = 0; moff = 0; mpend = -1; mwalk = 0; mtx = HX; mty = HY;
  endtask

  task automatic model_edge(input bit en, input bit fh, input bit stb,
                            input logic [7:0] code, input bit tick);
    int d, req, nx, ny;
    d = (stb && en) ? code_dir(code) : -1;
    if (fh) begin
      mx = HX; my = HY; mface = 1; moff = 0; mwalk = 0; mpend = -1;
    end else if (ANIM && mwalk) begin
      if (!en) begin
        moff = 0; mwalk = 0; mpend = -1;
      end else begin
        if (d >= 0) mpend = d;
        if (tick) begin
          if (moff + 32 / SF >= 32) begin
            mx = mtx; my = mty; moff = 0; mwalk = 0;
          end else begin
            moff = moff + 32 / SF;
          end
        end
      end
    end else begin
      req = d;
      if (req < 0 && mpend >= 0 && en) req = mpend;
      mpend = -1;
      if (req >= 0) begin
        mface = req;
        nx = mx + ((req == 2) ? -1 : (req == 3) ? 1 : 0);
        ny = my + ((req == 1) ? -1 : (req == 0) ? 1 : 0);
        if (!mblocked(nx, ny)) begin
          if (ANIM) begin
            mwalk = 1; mtx = nx; mty = ny;
          end else begin
            mx = nx; my = ny;
          end
        end
      end
    end
  endtask

  // One clock of stimulus; the model advances with the DUT on the edge.
  task automatic drive(input bit en, input bit fh, input bit stb,
                       input logic [7:0] code, input bit tick);
    enable = en; force_home = fh; kb_data_avail = stb; kb_data = code; screen_tick = tick;
    @(posedge clock);
    model_edge(en, fh, stb, code, tick);
    #1;
    force_home = 1'b0; kb_data_avail = 1'b0; screen_tick = 1'b0;
  endtask

  // Strobe a key, then run frames until the step (and any pending one) ends.
  task automatic press(input logic [7:0] code);
    int n;
    drive(1, 0, 1, code, 0);
    n = 0;
    while ((mwalk || mpend >= 0) && n < 200) begin
      drive(1, 0, 0, 8'h00, n[0]);
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; force_home = 1'b0; kb_data_avail = 1'b0;
    kb_data = 8'h00; screen_tick = 1'b0; prof_tx = 3'd0; prof_ty = 3'd0;
    model_reset();
    #12;
    checks++; if (protag_x !== 3'd3 || protag_y !== 3'd7) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) expected (3,7)", protag_x, protag_y); end
    checks++; if (facing !== 2'b00) begin errors++; $display("FAIL reset_facing: got %0d expected 0", facing); end
    checks++; if (walk_off !== 5'd0 || moving !== 1'b0) begin errors++; $display("FAIL reset_walk: got off=%0d mov=%0d expected 0,0", walk_off, moving); end
    checks++; if (at_prof !== 1'b0 || at_comp !== 1'b0) begin errors++; $display("FAIL reset_flags: got prof=%0d comp=%0d expected 0,0", at_prof, at_comp); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_walk_up();
    drive(1, 0, 1, K_UP, 0);
    checks++; if (facing !== 2'(mface)) begin errors++; $display("FAIL walk_facing: got %0d expected %0d", facing, mface); end
    checks++; if (moving !== mwalk) begin errors++; $display("FAIL walk_start_moving: got %0d expected %0d", moving, mwalk); end
    for (int i = 0; i < SF; i++) begin
      drive(1, 0, 0, 8'h00, 1);
      checks++; if (walk_off !== 5'(moff) || moving !== mwalk || protag_y !== 3'(my)) begin
        errors++; $display("FAIL walk_tick%0d: got off=%0d mov=%0d y=%0d expected off=%0d mov=%0d y=%0d", i, walk_off, moving, protag_y, moff, mwalk, my);
      end
      drive(1, 0, 0, 8'h00, 0);
    end
    checks++; if (protag_x !== 3'd3 || protag_y !== 3'd6) begin errors++; $display("FAIL walk_end_pos: got (%0d,%0d) expected (3,6)", protag_x, protag_y); end
  endtask

  task automatic test_bump();
    press(K_UP);
    checks++; if (protag_x !== 3'd3 || protag_y !== 3'd6) begin errors++; $display("FAIL bump_pos: got (%0d,%0d) expected (3,6)", protag_x, protag_y); end
    checks++; if (facing !== 2'b01 || moving !== 1'b0) begin errors++; $display("FAIL bump_state: got face=%0d mov=%0d expected 1,0", facing, moving); end
  endtask

  task automatic test_border_comp();
    press(K_LEFT); press(K_LEFT); press(K_LEFT);
    press(K_UP); press(K_UP); press(K_UP);
    checks++; if (protag_x !== 3'(mx) || protag_y !== 3'(my)) begin errors++; $display("FAIL nav_pos: got (%0d,%0d) expected (%0d,%0d)", protag_x, protag_y, mx, my); end
    press(K_LEFT);
    checks++; if (protag_x !== 3'd0 || protag_y !== 3'd3 || facing !== 2'b10) begin errors++; $display("FAIL border_left: got (%0d,%0d) f=%0d expected (0,3) f=2", protag_x, protag_y, facing); end
    press(K_UP);
    press(K_UP);
    checks++; if (protag_x !== 3'd0 || protag_y !== 3'd2 || facing !== 2'b01) begin errors++; $display("FAIL comp_pos: got (%0d,%0d) f=%0d expected (0,2) f=1", protag_x, protag_y, facing); end
    checks++; if (at_comp !== 1'b1) begin errors++; $display("FAIL at_comp: got %0d expected 1", at_comp); end
  endtask

  task automatic test_pending();
    drive(1, 0, 1, K_DOWN, 0);
    for (int k = 0; k < SF; k++) begin
      // RIGHT early, DOWN on the commit tick: DOWN overwrites RIGHT.
      drive(1, 0, (k == 2) || (k == SF - 1), (k == 2) ? K_RIGHT : K_DOWN, 1);
      checks++; if (walk_off !== 5'(moff) || moving !== mwalk) begin errors++; $display("FAIL pend_walk%0d: got off=%0d mov=%0d expected %0d,%0d", k, walk_off, moving, moff, mwalk); end
    end
    for (int k = 0; k < 3 * SF && (mwalk || mpend >= 0 || k < 2); k++) begin
      drive(1, 0, 0, 8'h00, 1);
      checks++; if (protag_x !== 3'(mx) || protag_y !== 3'(my) || facing !== 2'(mface) || moving !== mwalk) begin
        errors++; $display("FAIL pend_follow%0d: got (%0d,%0d) f=%0d m=%0d expected (%0d,%0d) f=%0d m=%0d", k, protag_x, protag_y, facing, moving, mx, my, mface, mwalk);
      end
    end
  endtask

  task automatic test_abort();
    int sx, sy;
    sx = mx; sy = my;
    drive(1, 0, 1, K_UP, 0);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 8'h00, 1);
    checks++; if (walk_off !== 5'(moff)) begin errors++; $display("FAIL abort_pre_off: got %0d expected %0d", walk_off, moff); end
    drive(0, 0, 0, 8'h00, 1);
    checks++; if (walk_off !== 5'd0 || moving !== 1'b0) begin errors++; $display("FAIL abort_walk: got off=%0d mov=%0d expected 0,0", walk_off, moving); end
    checks++; if (protag_x !== 3'(mx) || protag_y !== 3'(my)) begin errors++; $display("FAIL abort_pos: got (%0d,%0d) expected (%0d,%0d) from (%0d,%0d)", protag_x, protag_y, mx, my, sx, sy); end
    drive(1, 0, 1, K_UP, 0);
    drive(1, 0, 0, 8'h00, 1);
    checks++; if (walk_off !== 5'(moff) || moving !== mwalk) begin errors++; $display("FAIL abort_restart: got off=%0d mov=%0d expected %0d,%0d", walk_off, moving, moff, mwalk); end
    press(K_RIGHT);
  endtask

  task automatic test_force_home();
    drive(1, 1, 0, 8'h00, 0);
    press(K_RIGHT); press(K_RIGHT);
    for (int k = 0; k < 5; k++) press(K_UP);
    checks++; if (protag_x !== 3'd5 || protag_y !== 3'd2) begin errors++; $display("FAIL fh_nav: got (%0d,%0d) expected (5,2)", protag_x, protag_y); end
    drive(1, 1, 1, K_RIGHT, 0);
    checks++; if (protag_x !== 3'd3 || protag_y !== 3'd7 || facing !== 2'b01) begin errors++; $display("FAIL fh_home: got (%0d,%0d) f=%0d expected (3,7) f=1", protag_x, protag_y, facing); end
    drive(1, 0, 0, 8'h00, 1);
    checks++; if (moving !== 1'b0 || walk_off !== 5'd0 || protag_x !== 3'd3) begin errors++; $display("FAIL fh_nostep: got mov=%0d off=%0d x=%0d expected 0,0,3", moving, walk_off, protag_x); end
    prof_tx = 3'd3; prof_ty = 3'd7; #1;
    checks++; if (at_prof !== 1'b1) begin errors++; $display("FAIL at_prof: got %0d expected 1", at_prof); end
    prof_ty = 3'd6; #1;
    checks++; if (at_prof !== 1'b0) begin errors++; $display("FAIL at_prof_off: got %0d expected 0", at_prof); end
  endtask

  task automatic test_random();
    logic [7:0] codes [6];
    bit en, fh, stb, tick;
    codes = '{K_UP, K_DOWN, K_LEFT, K_RIGHT, 8'h1C, 8'hE0};
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom % 16) != 0;
      fh   = ($urandom % 80) == 0;
      stb  = ($urandom % 3) == 0;
      tick = ($urandom % 2) == 0;
      if (c % 40 == 0) begin prof_tx = 3'($urandom); prof_ty = 3'($urandom); end
      drive(en, fh, stb, codes[$urandom % 6], tick);
      checks++; if (protag_x !== 3'(mx) || protag_y !== 3'(my) || facing !== 2'(mface)) begin
        errors++; $display("FAIL rnd_pos c%0d: got (%0d,%0d) f=%0d expected (%0d,%0d) f=%0d", c, protag_x, protag_y, facing, mx, my, mface);
      end
      checks++; if (walk_off !== 5'(moff) || moving !== mwalk) begin
        errors++; $display("FAIL rnd_walk c%0d: got off=%0d mov=%0d expected %0d,%0d", c, walk_off, moving, moff, mwalk);
      end
      checks++; if (at_prof !== ((mx == int'(prof_tx)) && (my == int'(prof_ty))) || at_comp !== m_at_comp()) begin
        errors++; $display("FAIL rnd_flags c%0d: got prof=%0d comp=%0d expected %0d,%0d", c, at_prof, at_comp, (mx == int'(prof_tx)) && (my == int'(prof_ty)), m_at_comp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk_up();
    test_bump();
    test_border_comp();
    test_pending();
    test_abort();
    test_force_home();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
